uart_rx_loader: RTL and testbench
=================================

UART_RX_LOADER -- requirements
Module: uart_rx_loader

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, meaning clk cycles per UART bit (50 MHz / 115200 baud); legal range 4..65535.
REQ-002 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port rx  input  1  UART serial line (8N1); idles high; asynchronous to clk.
REQ-005 SHALL have port byte_valid  output  1  one-cycle pulse; byte_data holds a new byte.
REQ-006 SHALL have port byte_data  output  8  last correctly framed byte.
REQ-007 SHALL have port frame_err  output  1  one-cycle pulse; stop bit sampled low.
REQ-008 SHALL have port wr_en  output  1  one-cycle pulse; write wr_data to instruction memory at wr_addr.
REQ-009 SHALL have port wr_addr  output  32  byte address of the current word; starts at 0.
REQ-010 SHALL have port wr_data  output  32  assembled instruction word.
REQ-011 SHALL have port busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-012 SHALL pass rx through a two-flop synchronizer; the FSM SHALL use only the synchronized value.
REQ-013 SHALL implement states IDLE, START, DATA, STOP.
REQ-014 SHALL leave IDLE for START when synchronized rx is low; the bit counter SHALL clear to 0.
REQ-015 In START, SHALL sample at count CLKS_PER_BIT/2 (integer division): low -> DATA with counter cleared; high -> glitch, return to IDLE with no output.
REQ-016 In DATA, SHALL sample every CLKS_PER_BIT cycles and shift in 8 bits LSB first; after bit 7 -> STOP.
REQ-017 In STOP, SHALL sample after CLKS_PER_BIT cycles: high -> byte accepted; low -> frame_err pulse, byte discarded.
REQ-018 After a frame error, SHALL wait in STOP until synchronized rx is high before returning to IDLE.
REQ-019 On an accepted byte, SHALL update byte_data and pulse byte_valid in the cycle after the stop-bit sample, then return to IDLE.
REQ-020 SHALL assemble words little-endian: byte index 0 -> wr_data[7:0], up to index 3 -> wr_data[31:24]; the 2-bit byte index SHALL increment per accepted byte.
REQ-021 On the byte with index 3, SHALL pulse wr_en in the same cycle as byte_valid, with the complete wr_data and the current wr_addr stable.
REQ-022 SHALL increment wr_addr by 4 in the cycle after each wr_en pulse; it SHALL wrap from 0xFFFFFFFC to 0x00000000.
REQ-023 A frame error SHALL reset the byte index to 0 and discard the partial word; wr_addr SHALL be unchanged.
REQ-024 wr_data bits not yet written in the current word SHALL retain their previous values; only wr_en qualifies wr_data.
REQ-025 byte_valid, wr_en and frame_err SHALL never be high in the same cycle as frame_err, except byte_valid with wr_en per REQ-021.
REQ-026 busy SHALL be low exactly when the FSM is in IDLE.

Reset
REQ-027 While rst is high, regardless of clk, SHALL force: state IDLE, counters 0, byte index 0, byte_valid 0, frame_err 0, wr_en 0, busy 0, byte_data 0x00, wr_data 0x00000000, wr_addr 0x00000000, synchronizer flops 1.
REQ-028 Reset asserted mid-frame SHALL abort the frame with no pulses; after release, reception SHALL restart at the next falling edge.

Verification (CLKS_PER_BIT=8 for simulation)
REQ-029 Send 0x55, stop bit 1 -> one byte_valid pulse, byte_data=0x55, no wr_en, busy low afterwards.
REQ-030 Send 0x13,0x05,0x50,0x00 -> wr_en once, wr_data=0x00500513, wr_addr=0x00000000; next cycle wr_addr=0x00000004.
REQ-031 Send a second word 0x93,0x05,0x70,0x00 -> wr_data=0x00700593, wr_addr=0x00000004.
REQ-032 Drive rx low for 2 cycles, then high -> no byte_valid, no frame_err, FSM back in IDLE.
REQ-033 Send 0x13,0x05, then 0xAA with stop bit 0, then 4 good bytes 0x13,0x05,0x50,0x00 -> frame_err once; only one wr_en, with wr_data=0x00500513, wr_addr=0x00000000.
REQ-034 Assert rst during DATA bit 3 of the second byte -> all outputs 0 immediately; the next full word is written at wr_addr=0x00000000.

Source files
------------

// File: rtl/uart_rx_loader.sv
// rtl/uart_rx_loader.sv - 8N1 UART receiver that packs bytes into 32-bit instruction-memory writes
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   rx         UART serial line, idles high, asynchronous to clk
//   byte_valid one-cycle pulse when byte_data holds a newly accepted byte
//   byte_data  last correctly framed byte
//   frame_err  one-cycle pulse when the stop bit was sampled low
//   wr_en      one-cycle pulse: write wr_data to instruction memory at wr_addr
//   wr_addr    byte address of the word being assembled, steps by 4 after each wr_en
//   wr_data    little-endian assembled word (only meaningful while wr_en is high)
//   busy       high whenever the receiver is not idle
module uart_rx_loader #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic        byte_valid,
  output logic [7:0]  byte_data,
  output logic        frame_err,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        busy
);

  localparam logic [15:0] HALF_BIT = 16'(CLKS_PER_BIT / 2);
  localparam logic [15:0] LAST_CLK = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      state;
  logic        rx_meta;
  logic        rx_sync;
  logic [15:0] clk_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift;
  logic [1:0]  byte_idx;
  logic        err_wait;   // frame error seen, holding in STOP until the line returns high

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rx_meta    <= 1'b1;
      rx_sync    <= 1'b1;
      clk_cnt    <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      byte_idx   <= '0;
      err_wait   <= 1'b0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      frame_err  <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
    end else begin
      rx_meta    <= rx;
      rx_sync    <= rx_meta;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      wr_en      <= 1'b0;

      // The address advances the cycle after the write so wr_addr is stable during wr_en.
      if (wr_en) begin
        wr_addr <= wr_addr + 32'd4;
      end

      case (state)
        IDLE: begin
          if (!rx_sync) begin
            state   <= START;
            clk_cnt <= '0;
          end
        end

        START: begin
          // Re-check the start bit at its midpoint; a high level here is a glitch.
          if (clk_cnt == HALF_BIT) begin
            clk_cnt <= '0;
            bit_cnt <= '0;
            state   <= rx_sync ? IDLE : DATA;
          end else begin
            clk_cnt <= clk_cnt + 16'd1;
          end
        end

        DATA: begin
          if (clk_cnt == LAST_CLK) begin
            clk_cnt <= '0;
            shift   <= {rx_sync, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state <= STOP;
            end
          end else begin
            clk_cnt <= clk_cnt + 16'd1;
          end
        end

        STOP: begin
          if (err_wait) begin
            if (rx_sync) begin
              err_wait <= 1'b0;
              state    <= IDLE;
            end
          end else if (clk_cnt == LAST_CLK) begin
            clk_cnt <= '0;
            if (rx_sync) begin
              byte_valid                       <= 1'b1;
              byte_data                        <= shift;
              wr_data[{byte_idx, 3'b000} +: 8] <= shift;
              wr_en                            <= (byte_idx == 2'd3);
              byte_idx                         <= byte_idx + 2'd1;
              state                            <= IDLE;
            end else begin
              // Bad framing throws away the partial word but keeps the address.
              frame_err <= 1'b1;
              byte_idx  <= '0;
              err_wait  <= 1'b1;
            end
          end else begin
            clk_cnt <= clk_cnt + 16'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_loader.sv
// tb/tb_uart_rx_loader.sv - scoreboard testbench for uart_rx_loader
module tb_uart_rx_loader;

  localparam int CPB = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx  = 1'b1;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        frame_err;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        busy;

  uart_rx_loader #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .rx(rx),
    .byte_valid(byte_valid), .byte_data(byte_data), .frame_err(frame_err),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: what a loader should do with the frames actually sent.
  logic [7:0]  exp_bytes[$];
  logic [63:0] exp_words[$];   // {addr, data}
  int          exp_errs = 0;
  logic [7:0]  m_word[4];
  int          m_idx  = 0;
  logic [31:0] m_addr = 0;

  bit          addr_chk_pending = 0;
  logic [31:0] addr_chk_value;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_idx  = 0;
    m_addr = 0;
  endtask

  task automatic model_frame(input logic [7:0] b, input bit stop);
    if (stop) begin
      exp_bytes.push_back(b);
      m_word[m_idx] = b;
      if (m_idx == 3) begin
        exp_words.push_back({m_addr, m_word[3], m_word[2], m_word[1], m_word[0]});
        m_addr = m_addr + 32'd4;
      end
      m_idx = (m_idx + 1) % 4;
    end else begin
      exp_errs++;
      m_idx = 0;
    end
  endtask

  task automatic line_bit(input logic v);
    rx = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop, input int gap);
    int g;
    model_frame(b, stop);
    line_bit(1'b0);
    for (int i = 0; i < 8; i++) line_bit(b[i]);
    line_bit(stop);
    rx = 1'b1;
    g = (!stop && gap < 4) ? 4 : gap;
    repeat (g) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    rx  = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk(byte_valid == 0, {tag, " byte_valid"}, 64'(byte_valid), 0);
    chk(frame_err == 0,  {tag, " frame_err"},  64'(frame_err), 0);
    chk(wr_en == 0,      {tag, " wr_en"},      64'(wr_en), 0);
    chk(busy == 0,       {tag, " busy"},       64'(busy), 0);
    chk(byte_data == 0,  {tag, " byte_data"},  64'(byte_data), 0);
    chk(wr_data == 0,    {tag, " wr_data"},    64'(wr_data), 0);
    chk(wr_addr == 0,    {tag, " wr_addr"},    64'(wr_addr), 0);
  endtask

  // Monitor: pops expectations whenever the DUT presents an output pulse.
  always @(negedge clk) begin
    if (rst) begin
      addr_chk_pending = 0;
    end else begin
      if (addr_chk_pending) begin
        chk(wr_addr == addr_chk_value, "wr_addr_step", 64'(wr_addr), 64'(addr_chk_value));
        addr_chk_pending = 0;
      end
      if (frame_err) begin
        chk(!byte_valid && !wr_en, "err_exclusive", {62'd0, byte_valid, wr_en}, 0);
        chk(exp_errs > 0, "unexpected_frame_err", 1, 0);
        if (exp_errs > 0) exp_errs--;
      end
      if (byte_valid) begin
        if (exp_bytes.size() == 0) begin
          chk(1'b0, "unexpected_byte_valid", 64'(byte_data), 0);
        end else begin
          logic [7:0] eb;
          eb = exp_bytes.pop_front();
          chk(byte_data == eb, "byte_data", 64'(byte_data), 64'(eb));
        end
      end
      if (wr_en) begin
        chk(byte_valid == 1'b1, "wr_en_with_byte_valid", 64'(byte_valid), 1);
        if (exp_words.size() == 0) begin
          chk(1'b0, "unexpected_wr_en", {wr_addr, wr_data}, 0);
        end else begin
          logic [63:0] ew;
          ew = exp_words.pop_front();
          chk(wr_addr == ew[63:32], "wr_addr", 64'(wr_addr), 64'(ew[63:32]));
          chk(wr_data == ew[31:0],  "wr_data", 64'(wr_data), 64'(ew[31:0]));
          addr_chk_value   = ew[63:32] + 32'd4;
          addr_chk_pending = 1;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] rb;
    bit         rs;

    // Reset state
    #1;
    chk_all_zero("reset");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single byte, no write
    send_frame(8'h55, 1'b1, 4);
    chk(busy == 0, "busy_after_byte", 64'(busy), 0);

    // Two words (fresh reset so the first word lands at address 0)
    do_reset();
    send_frame(8'h13, 1, 0); send_frame(8'h05, 1, 0);
    send_frame(8'h50, 1, 0); send_frame(8'h00, 1, 2);
    send_frame(8'h93, 1, 1); send_frame(8'h05, 1, 0);
    send_frame(8'h70, 1, 3); send_frame(8'h00, 1, 4);

    // Start-bit glitch
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (2) @(negedge clk);
    chk(busy == 1, "busy_during_glitch", 64'(busy), 1);
    repeat (10) @(negedge clk);
    chk(busy == 0, "busy_after_glitch", 64'(busy), 0);

    // Frame error discards the partial word
    do_reset();
    send_frame(8'h13, 1, 0); send_frame(8'h05, 1, 0);
    send_frame(8'hAA, 0, 4);
    send_frame(8'h13, 1, 0); send_frame(8'h05, 1, 0);
    send_frame(8'h50, 1, 0); send_frame(8'h00, 1, 4);

    // Reset during data bit 3 of the second byte
    do_reset();
    send_frame(8'h13, 1, 0);
    line_bit(1'b0);
    for (int i = 0; i < 3; i++) line_bit(1'b1);
    repeat (CPB / 2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk_all_zero("midframe_reset");
    model_reset();
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    send_frame(8'h37, 1, 0); send_frame(8'h11, 1, 0);
    send_frame(8'h22, 1, 0); send_frame(8'h33, 1, 4);

    // Randomized traffic
    for (int n = 0; n < 48; n++) begin
      rb = 8'($urandom);
      rs = ($urandom_range(0, 9) != 0);
      send_frame(rb, rs, $urandom_range(0, 5));
    end

    repeat (20) @(negedge clk);
    chk(exp_bytes.size() == 0, "bytes_outstanding", 64'(exp_bytes.size()), 0);
    chk(exp_words.size() == 0, "words_outstanding", 64'(exp_words.size()), 0);
    chk(exp_errs == 0, "errs_outstanding", 64'(exp_errs), 0);
    chk(busy == 0, "busy_final", 64'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
